ddl_reply_arbiter: RTL and testbench
====================================

// Module: ddl_reply_arbiter
// PURPOSE
//  Shares the DDL encoder's single reply channel (ddl_ReplyReq/ddl_Reply/ddl_ReplyAck) among N_REQ reply sources.
//  Sources include the command decoder, slow-control and status readback.
//  Round-robin arbitration; the winning word is latched and held until the encoder acknowledges it.
//  Enforces an inter-reply gap so the encoder can interleave idle and diagnostic frames.
// PARAMETERS
//  N_REQ          4      number of reply requesters (2..8)
//  GAP_CYCLES     4      idle cycles after each reply before next arbitration (>=1)
//  TIMEOUT_CYCLES 1024   encoder-ack timeout in cycles (used only with DDL_REPLY_TIMEOUT_EN)
// PORTS
//  rd_clk        in   1         encoder clock; all logic on rising edge
//  reset_n       in   1         asynchronous, active-low reset
//  enable        in   1         1 = arbitration allowed; 0 = no new grant (current reply completes)
//  req_i         in   N_REQ     level request per source; held with reply_i stable until ack_o
//  reply_i       in   32*N_REQ  reply word per source; source k at [32k+31:32k]
//  ack_o         out  N_REQ     one-cycle pulse to the served source
//  ddl_ReplyReq  out  1         reply request to encoder
//  ddl_Reply     out  32        latched reply word to encoder
//  ddl_ReplyAck  in   1         one-cycle ack from encoder
//  grant_idx     out  3         index of last/current grant
//  busy          out  1         1 when state != IDLE
//  reply_cnt     out  16        replies completed; wraps 0xFFFF->0
//  err_clr       in   1         clears timeout_err
//  timeout_err   out  1         sticky encoder-ack timeout flag
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE; ack_o=0; ddl_ReplyReq=0; ddl_Reply=0; grant_idx=0.
//   Also busy=0, reply_cnt=0, timeout_err=0; last_grant=N_REQ-1 so source 0 has first priority.
//  Reset mid-transfer: the reply is dropped silently and no ack_o is issued.
//  FSM states: IDLE, SEND, GAP.
//  IDLE: if enable && |req_i, the winner is the first set bit searching from last_grant+1 upward, wrapping.
//   On that edge: grant_idx<=winner; ddl_Reply<=reply_i[winner]; ddl_ReplyReq<=1; ->SEND.
//   Latency: req_i seen -> ddl_ReplyReq high 1 cycle later.
//  SEND: ddl_ReplyReq and ddl_Reply are held stable; req_i changes are ignored because the word is latched.
//   On ddl_ReplyAck=1, same edge: ddl_ReplyReq<=0; ack_o[grant_idx]<=1 for exactly 1 cycle.
//   Also reply_cnt<=reply_cnt+1; last_grant<=grant_idx; gap counter<=0; ->GAP.
//   ddl_ReplyReq must be low the cycle after the ack so the encoder does not resend.
//  GAP: ddl_ReplyReq=0; count GAP_CYCLES cycles, then ->IDLE.
//   Sources drop req_i the cycle after ack_o. Because GAP_CYCLES>=1, the served source is never regranted on a stale request.
//  ddl_ReplyAck outside SEND: ignored; no state change, no counter change.
//  ddl_ReplyAck in the same cycle as entering SEND: cannot occur, since the request is registered. The bench checks that it is ignored.
//  enable=0 in SEND or GAP: the current reply completes normally; the FSM then stays in IDLE.
//  All requests set: strict rotation 0,1,2,3,0,...; every source is served once per N_REQ grants.
//  busy = (state != IDLE); grant_idx holds its value in IDLE.
// CONFIGURATION
//  DDL_REPLY_TIMEOUT_EN defined:
//   - A counter runs in SEND. When it reaches TIMEOUT_CYCLES without ddl_ReplyAck: ddl_ReplyReq<=0; ack_o[grant_idx] pulses; timeout_err<=1 (sticky); reply_cnt unchanged; last_grant advances; ->GAP.
//   - err_clr=1 clears timeout_err, unless a timeout fires in the same cycle (set wins).
//  DDL_REPLY_TIMEOUT_EN undefined:
//   - SEND waits indefinitely; timeout_err is tied 0; err_clr is ignored; ports are unchanged.
// TESTING
//  1 Single source: req_i=4'b0100, reply_i[2]=32'hCAFE_0001, ack after 6 cycles -> ddl_Reply=32'hCAFE_0001 held 6 cycles; ack_o=4'b0100 one cycle; reply_cnt=1; next grant only after 4 gap cycles.
//  2 Fairness: req_i=4'hF held, 8 acks -> grant order 0,1,2,3,0,1,2,3; each ack_o bit pulses twice.
//  3 Stability: source 1 changes reply_i and drops req_i mid-SEND -> ddl_Reply keeps the originally latched value; transfer completes; ack_o[1] pulses.
//  4 Reset mid-SEND: reset_n=0 for 1 cycle -> ddl_ReplyReq=0 immediately, no ack_o; after release, source 0 wins first.
//  5 enable=0 asserted in SEND -> reply completes, ack_o pulses, busy=0 after GAP, no new ddl_ReplyReq while req_i=4'hF.
//  6 With DDL_REPLY_TIMEOUT_EN and TIMEOUT_CYCLES=16: no ack -> ddl_ReplyReq drops at cycle 16; timeout_err=1; reply_cnt unchanged; err_clr pulse -> timeout_err=0.

Source files
------------

// File: rtl/ddl_reply_arbiter_if.sv
// Reply channel bundle shared by the reply sources and the DDL encoder.
// master: arbiter side; slave: sources + encoder side.
interface ddl_reply_arbiter_if #(
    parameter int unsigned N_REQ = 4
);
    logic [N_REQ-1:0]    req_i;
    logic [32*N_REQ-1:0] reply_i;
    logic [N_REQ-1:0]    ack_o;
    logic                ddl_ReplyReq;
    logic [31:0]         ddl_Reply;
    logic                ddl_ReplyAck;

    modport master (
        input  req_i, reply_i, ddl_ReplyAck,
        output ack_o, ddl_ReplyReq, ddl_Reply
    );

    modport slave (
        output req_i, reply_i, ddl_ReplyAck,
        input  ack_o, ddl_ReplyReq, ddl_Reply
    );
endinterface

// File: rtl/ddl_reply_arbiter.sv
// Round-robin arbiter sharing the DDL encoder reply channel among N_REQ sources.
// The winning word is latched and held until the encoder acks, followed by a
// GAP_CYCLES idle gap before the next arbitration.
// Optional feature: define DDL_REPLY_TIMEOUT_EN to abort a reply after
// TIMEOUT_CYCLES without ddl_ReplyAck (sets sticky timeout_err).
module ddl_reply_arbiter #(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                     rd_clk,
    input  logic                     reset_n,
    input  logic                     enable,
    ddl_reply_arbiter_if.master      bus,
    output logic [2:0]               grant_idx,
    output logic                     busy,
    output logic [15:0]              reply_cnt,
    input  logic                     err_clr,
    output logic                     timeout_err
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    state_t            state_q;
    logic [N_REQ-1:0]  ack_q;
    logic              req_q;
    logic [31:0]       reply_q;
    logic [2:0]        grant_q;
    logic [2:0]        last_q;
    logic [15:0]       cnt_q;
    logic [GW-1:0]     gap_q;

    logic [2:0]        winner;
    logic              found;
    logic [31:0]       cand;

    // Round-robin search: first requesting source after last_q, wrapping.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = 32'(last_q) + i;
            if (cand >= N_REQ) cand = cand - N_REQ;
            if (!found && bus.req_i[cand[IW-1:0]]) begin
                winner = 3'(cand);
                found  = 1'b1;
            end
        end
    end

`ifdef DDL_REPLY_TIMEOUT_EN
    logic [TW-1:0] tmo_q;
    logic          terr_q;
`else
    localparam int unsigned UNUSED_TW = TW;
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
`endif

    // Arbitration FSM with registered channel outputs.
    always_ff @(posedge rd_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ack_q   <= '0;
            req_q   <= 1'b0;
            reply_q <= '0;
            grant_q <= '0;
            last_q  <= 3'(N_REQ - 1);
            cnt_q   <= '0;
            gap_q   <= '0;
`ifdef DDL_REPLY_TIMEOUT_EN
            tmo_q   <= '0;
            terr_q  <= 1'b0;
`endif
        end else begin
            ack_q <= '0;
`ifdef DDL_REPLY_TIMEOUT_EN
            // Clear first so a timeout in the same cycle wins.
            if (err_clr) terr_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (enable && found) begin
                        grant_q <= winner;
                        reply_q <= bus.reply_i[32*winner +: 32];
                        req_q   <= 1'b1;
                        state_q <= SEND;
`ifdef DDL_REPLY_TIMEOUT_EN
                        tmo_q   <= '0;
`endif
                    end
                end
                SEND: begin
                    if (bus.ddl_ReplyAck) begin
                        req_q                  <= 1'b0;
                        ack_q[grant_q[IW-1:0]] <= 1'b1;
                        cnt_q                  <= cnt_q + 16'd1;
                        last_q                 <= grant_q;
                        gap_q                  <= '0;
                        state_q                <= GAP;
                    end
`ifdef DDL_REPLY_TIMEOUT_EN
                    else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        req_q                  <= 1'b0;
                        ack_q[grant_q[IW-1:0]] <= 1'b1;
                        terr_q                 <= 1'b1;
                        last_q                 <= grant_q;
                        gap_q                  <= '0;
                        state_q                <= GAP;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                GAP: begin
                    if (gap_q == GW'(GAP_CYCLES - 1)) state_q <= IDLE;
                    else                              gap_q   <= gap_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ack_o        = ack_q;
    assign bus.ddl_ReplyReq = req_q;
    assign bus.ddl_Reply    = reply_q;
    assign grant_idx        = grant_q;
    assign busy             = (state_q != IDLE);
    assign reply_cnt        = cnt_q;
`ifdef DDL_REPLY_TIMEOUT_EN
    assign timeout_err      = terr_q;
`else
    assign timeout_err      = 1'b0;
`endif

endmodule

// File: tb/tb_ddl_reply_arbiter.sv
// Directed bench for ddl_reply_arbiter (N_REQ=4, GAP_CYCLES=4, TIMEOUT_CYCLES=16).
module tb_ddl_reply_arbiter;

    localparam int unsigned N = 4;

    logic        rd_clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        err_clr;
    logic [2:0]  grant_idx;
    logic        busy;
    logic [15:0] reply_cnt;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;
    int ackcnt [4];
    int w;

    ddl_reply_arbiter_if #(.N_REQ(N)) bus ();

    ddl_reply_arbiter #(
        .N_REQ(N),
        .GAP_CYCLES(4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .rd_clk(rd_clk),
        .reset_n(reset_n),
        .enable(enable),
        .bus(bus.master),
        .grant_idx(grant_idx),
        .busy(busy),
        .reply_cnt(reply_cnt),
        .err_clr(err_clr),
        .timeout_err(timeout_err)
    );

    always #5 rd_clk = ~rd_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic ack_pulse();
        bus.ddl_ReplyAck = 1'b1;
        tick();
        bus.ddl_ReplyAck = 1'b0;
    endtask

    task automatic idle_wait();
        int n;
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        chk("idle_wait", busy, 1'b0);
    endtask

    task automatic count_acks();
        for (int k = 0; k < 4; k++) ackcnt[k] += int'(bus.ack_o[k]);
    endtask

    initial begin
        reset_n          = 1'b0;
        enable           = 1'b1;
        err_clr          = 1'b0;
        bus.req_i        = '0;
        bus.reply_i      = '0;
        bus.ddl_ReplyAck = 1'b0;
        for (int k = 0; k < 4; k++) ackcnt[k] = 0;

        // Reset state
        tick(); tick();
        chk("rst_req",   bus.ddl_ReplyReq, 1'b0);
        chk("rst_reply", bus.ddl_Reply, 32'h0);
        chk("rst_ack",   bus.ack_o, 4'h0);
        chk("rst_grant", grant_idx, 3'd0);
        chk("rst_busy",  busy, 1'b0);
        chk("rst_cnt",   reply_cnt, 16'd0);
        chk("rst_terr",  timeout_err, 1'b0);
        reset_n = 1'b1;
        tick();

        // 1: single source 2, ack after 6 cycles, gap of 4
        bus.reply_i[32*2 +: 32] = 32'hCAFE_0001;
        bus.reply_i[32*3 +: 32] = 32'h3333_0003;
        bus.req_i = 4'b0100;
        tick();
        chk("t1_req",   bus.ddl_ReplyReq, 1'b1);
        chk("t1_word",  bus.ddl_Reply, 32'hCAFE_0001);
        chk("t1_grant", grant_idx, 3'd2);
        chk("t1_busy",  busy, 1'b1);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("t1_hold_req",  bus.ddl_ReplyReq, 1'b1);
            chk("t1_hold_word", bus.ddl_Reply, 32'hCAFE_0001);
        end
        ack_pulse();
        chk("t1_ack",     bus.ack_o, 4'b0100);
        chk("t1_req_low", bus.ddl_ReplyReq, 1'b0);
        chk("t1_cnt",     reply_cnt, 16'd1);
        bus.req_i = 4'b1000;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t1_gap_busy", busy, 1'b1);
            chk("t1_gap_req",  bus.ddl_ReplyReq, 1'b0);
            chk("t1_gap_ack",  bus.ack_o, 4'h0);
        end
        tick();
        chk("t1_idle_busy", busy, 1'b0);
        chk("t1_idle_req",  bus.ddl_ReplyReq, 1'b0);
        tick();
        chk("t1_next_req",   bus.ddl_ReplyReq, 1'b1);
        chk("t1_next_grant", grant_idx, 3'd3);
        chk("t1_next_word",  bus.ddl_Reply, 32'h3333_0003);
        ack_pulse();
        chk("t1_next_ack", bus.ack_o, 4'b1000);
        chk("t1_cnt2",     reply_cnt, 16'd2);

        // 2: fairness with all requests held
        for (int k = 0; k < 4; k++) bus.reply_i[32*k +: 32] = 32'hA000_0000 + k;
        bus.req_i = 4'hF;
        for (int g = 0; g < 8; g++) begin
            w = 0;
            while (!bus.ddl_ReplyReq && w < 20) begin
                tick();
                count_acks();
                w++;
            end
            chk("t2_req",   bus.ddl_ReplyReq, 1'b1);
            chk("t2_grant", grant_idx, 32'(g % 4));
            chk("t2_word",  bus.ddl_Reply, 32'hA000_0000 + 32'(g % 4));
            ack_pulse();
            count_acks();
            chk("t2_ack",   bus.ack_o, 32'(1 << (g % 4)));
        end
        bus.req_i = '0;
        tick();
        count_acks();
        for (int k = 0; k < 4; k++) chk("t2_ackcnt", ackcnt[k], 2);
        chk("t2_cnt", reply_cnt, 16'd10);
        idle_wait();

        // 3: reply word stays latched while source changes it mid-SEND
        bus.reply_i[32*1 +: 32] = 32'h1111_1111;
        bus.req_i = 4'b0010;
        tick();
        chk("t3_grant", grant_idx, 3'd1);
        chk("t3_word",  bus.ddl_Reply, 32'h1111_1111);
        bus.reply_i[32*1 +: 32] = 32'h2222_2222;
        bus.req_i = 4'b0000;
        tick(); tick();
        chk("t3_hold_req",  bus.ddl_ReplyReq, 1'b1);
        chk("t3_hold_word", bus.ddl_Reply, 32'h1111_1111);
        ack_pulse();
        chk("t3_ack", bus.ack_o, 4'b0010);
        chk("t3_cnt", reply_cnt, 16'd11);
        idle_wait();

        // 4: reset mid-SEND
        bus.req_i = 4'b1000;
        tick();
        chk("t4_req",   bus.ddl_ReplyReq, 1'b1);
        chk("t4_grant", grant_idx, 3'd3);
        reset_n = 1'b0;
        #1;
        chk("t4_rst_req",  bus.ddl_ReplyReq, 1'b0);
        chk("t4_rst_busy", busy, 1'b0);
        chk("t4_rst_cnt",  reply_cnt, 16'd0);
        tick();
        chk("t4_rst_ack", bus.ack_o, 4'h0);
        reset_n   = 1'b1;
        bus.req_i = 4'hF;
        tick();
        chk("t4_first_grant", grant_idx, 3'd0);
        chk("t4_first_req",   bus.ddl_ReplyReq, 1'b1);
        chk("t4_first_ack",   bus.ack_o, 4'h0);

        // 5: enable dropped during SEND
        enable = 1'b0;
        tick();
        chk("t5_req", bus.ddl_ReplyReq, 1'b1);
        ack_pulse();
        chk("t5_ack", bus.ack_o, 4'b0001);
        chk("t5_cnt", reply_cnt, 16'd1);
        idle_wait();
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("t5_no_req", bus.ddl_ReplyReq, 1'b0);
        end
        enable = 1'b1;
        tick();
        chk("t5_resume_req",   bus.ddl_ReplyReq, 1'b1);
        chk("t5_resume_grant", grant_idx, 3'd1);
        ack_pulse();
        chk("t5_resume_cnt", reply_cnt, 16'd2);
        bus.req_i = '0;
        idle_wait();

        // Ack outside SEND is ignored
        ack_pulse();
        chk("stray_cnt",  reply_cnt, 16'd2);
        chk("stray_busy", busy, 1'b0);
        chk("stray_ack",  bus.ack_o, 4'h0);

        // Ack coinciding with the grant edge is ignored
        bus.reply_i[32*2 +: 32] = 32'h5A5A_0002;
        bus.req_i        = 4'b0100;
        bus.ddl_ReplyAck = 1'b1;
        tick();
        bus.ddl_ReplyAck = 1'b0;
        chk("early_req",   bus.ddl_ReplyReq, 1'b1);
        chk("early_grant", grant_idx, 3'd2);
        tick();
        chk("early_hold", bus.ddl_ReplyReq, 1'b1);
        chk("early_ack",  bus.ack_o, 4'h0);
        chk("early_cnt",  reply_cnt, 16'd2);
        ack_pulse();
        chk("early_ack2", bus.ack_o, 4'b0100);
        chk("early_cnt2", reply_cnt, 16'd3);
        bus.req_i = '0;
        idle_wait();

        // 6: no ack from the encoder
        bus.req_i = 4'b0001;
        tick();
        chk("t6_req", bus.ddl_ReplyReq, 1'b1);
        repeat (15) tick();
        chk("t6_req15", bus.ddl_ReplyReq, 1'b1);
`ifdef DDL_REPLY_TIMEOUT_EN
        tick();
        chk("t6_tmo_req",  bus.ddl_ReplyReq, 1'b0);
        chk("t6_tmo_ack",  bus.ack_o, 4'b0001);
        chk("t6_tmo_err",  timeout_err, 1'b1);
        chk("t6_tmo_cnt",  reply_cnt, 16'd3);
        bus.req_i = '0;
        tick();
        chk("t6_err_sticky", timeout_err, 1'b1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t6_err_clr", timeout_err, 1'b0);
`else
        repeat (10) tick();
        chk("t6_wait_req", bus.ddl_ReplyReq, 1'b1);
        chk("t6_no_err",   timeout_err, 1'b0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t6_clr_err",  timeout_err, 1'b0);
        ack_pulse();
        chk("t6_late_ack", bus.ack_o, 4'b0001);
        chk("t6_late_cnt", reply_cnt, 16'd4);
        bus.req_i = '0;
`endif
        idle_wait();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
